// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sobel_pkg
// Purpose  : Shared types and constants for the Sobel scan controller:
//            FSM state encoding, default widths, clamp limit and the
//            3x3 window offsets walked by the fetch sequence.
// Revision : 1.0 - initial release
// ============================================================================
package sobel_pkg;

    localparam int DEF_PIX_W  = 12;
    localparam int DEF_ADDR_W = 10;

    // Largest representable pixel value; gradient magnitudes saturate here
    localparam int PIX_MAX = (1 << DEF_PIX_W) - 1;

    // Window offsets biased by +1 (0..2) so they stay unsigned; window
    // index k maps to dy = K_ROW_OFS[k]-1, dx = K_COL_OFS[k]-1
    localparam logic [1:0] K_ROW_OFS [0:8] = '{2'd0, 2'd0, 2'd0,
                                               2'd1, 2'd1, 2'd1,
                                               2'd2, 2'd2, 2'd2};
    localparam logic [1:0] K_COL_OFS [0:8] = '{2'd0, 2'd1, 2'd2,
                                               2'd0, 2'd1, 2'd2,
                                               2'd0, 2'd1, 2'd2};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        WAIT    = 3'd2,
        COMPUTE = 3'd3,
        EMIT    = 3'd4,
        DONE    = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sobel_kernel.sv
`default_nettype none
// ============================================================================
// Module   : sobel_kernel
// Purpose  : Combinational 3x3 Sobel operator. Produces |Gx|+|Gy| for the
//            window win[0..8] (row-major) saturated to the pixel range.
// Revision : 1.0 - initial release
// ============================================================================
module sobel_kernel
    import sobel_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W
) (
    input  logic [PIX_W-1:0] win [0:8],
    output logic [PIX_W-1:0] mag
);

    // Partial sums hold up to 4*max pixel, gradients one sign bit more,
    // and the magnitude one more carry bit on top of that
    localparam int SW = PIX_W + 2;
    localparam int GW = PIX_W + 3;
    localparam int MW = PIX_W + 4;
    localparam logic [MW-1:0] MAG_CLAMP = MW'((1 << PIX_W) - 1);

    logic        [SW-1:0] w_xp;
    logic        [SW-1:0] w_xn;
    logic        [SW-1:0] w_yp;
    logic        [SW-1:0] w_yn;
    logic signed [GW-1:0] w_gx;
    logic signed [GW-1:0] w_gy;
    logic        [GW-1:0] w_ax;
    logic        [GW-1:0] w_ay;
    logic        [MW-1:0] w_mag;

    // Weighted column/row sums, both gradients, absolute sum and saturation
    always_comb begin
        w_xp  = SW'(win[2]) + SW'({win[5], 1'b0}) + SW'(win[8]);
        w_xn  = SW'(win[0]) + SW'({win[3], 1'b0}) + SW'(win[6]);
        w_yp  = SW'(win[6]) + SW'({win[7], 1'b0}) + SW'(win[8]);
        w_yn  = SW'(win[0]) + SW'({win[1], 1'b0}) + SW'(win[2]);
        w_gx  = $signed(GW'(w_xp)) - $signed(GW'(w_xn));
        w_gy  = $signed(GW'(w_yp)) - $signed(GW'(w_yn));
        w_ax  = w_gx[GW-1] ? GW'(-w_gx) : GW'(w_gx);
        w_ay  = w_gy[GW-1] ? GW'(-w_gy) : GW'(w_gy);
        w_mag = MW'(w_ax) + MW'(w_ay);
        mag   = (w_mag > MAG_CLAMP) ? MAG_CLAMP[PIX_W-1:0] : w_mag[PIX_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/sobel_sched.sv
`default_nettype none
// ============================================================================
// Module   : sobel_sched
// Purpose  : Owns the shared pixel memory. In IDLE the host may write the
//            image; once started, the scan engine walks every interior
//            pixel, fetches its 3x3 window, and streams one clamped Sobel
//            magnitude per pixel over a valid/ready interface.
// Revision : 1.0 - initial release
// ============================================================================
module sobel_sched
    import sobel_pkg::*;
#(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int PIX_W  = DEF_PIX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_wr,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [PIX_W-1:0]  host_data,
    output logic              host_ready,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [PIX_W-1:0]  mem_wr_data,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [PIX_W-1:0]  mem_rd_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ADDR_W-1:0] res_addr,
    output logic [PIX_W-1:0]  res_mag
);

    localparam logic [ADDR_W-1:0] C_ONE     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] C_LAST_C  = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] C_LAST_R  = ADDR_W'(IMG_H - 2);
    localparam logic [ADDR_W-1:0] C_WIDTH   = ADDR_W'(IMG_W);

    state_t            r_state;
    logic [ADDR_W-1:0] r_row;
    logic [ADDR_W-1:0] r_col;
    logic [3:0]        r_k;
    logic [PIX_W-1:0]  r_win [0:8];
    logic [ADDR_W-1:0] r_res_addr;
    logic [PIX_W-1:0]  r_res_mag;

    logic              w_busy;
    logic [ADDR_W-1:0] w_win_row;
    logic [ADDR_W-1:0] w_win_col;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [PIX_W-1:0]  w_mag;

    // Window pixel address for the current fetch index; row/col >= 1 so the
    // -1 bias never underflows
    always_comb begin
        w_win_row = r_row + ADDR_W'(K_ROW_OFS[r_k]) - C_ONE;
        w_win_col = r_col + ADDR_W'(K_COL_OFS[r_k]) - C_ONE;
        w_rd_addr = ADDR_W'(w_win_row * C_WIDTH + w_win_col);
    end

    sobel_kernel #(
        .PIX_W (PIX_W)
    ) u_kernel (
        .win (r_win),
        .mag (w_mag)
    );

    // Memory write port belongs to the host only while the scan is idle;
    // host_ready is held low during reset so every output reads zero there
    always_comb begin
        w_busy      = (r_state == FETCH) || (r_state == WAIT) ||
                      (r_state == COMPUTE) || (r_state == EMIT);
        host_ready  = rst_n && (r_state == IDLE);
        mem_wr_en   = host_wr && host_ready;
        mem_wr_addr = host_addr;
        mem_wr_data = host_data;
        mem_rd_addr = (r_state == FETCH) ? w_rd_addr : '0;
        busy        = w_busy;
        done        = (r_state == DONE);
        res_valid   = (r_state == EMIT);
        res_addr    = r_res_addr;
        res_mag     = r_res_mag;
    end

    // Scan sequencer: fetch window, compute, hand off, advance raster position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_row      <= C_ONE;
            r_col      <= C_ONE;
            r_k        <= 4'd0;
            r_res_addr <= '0;
            r_res_mag  <= '0;
            for (int i = 0; i < 9; i++) begin
                r_win[i] <= '0;
            end
        end else if (abort && w_busy) begin
            // Abort wins over a simultaneous handshake; the pending result is dropped
            r_state <= IDLE;
            r_row   <= C_ONE;
            r_col   <= C_ONE;
            r_k     <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= FETCH;
                        r_row   <= C_ONE;
                        r_col   <= C_ONE;
                        r_k     <= 4'd0;
                    end
                end
                FETCH: begin
                    // Read data lags the address by one cycle
                    if (r_k != 4'd0) begin
                        r_win[r_k - 4'd1] <= mem_rd_data;
                    end
                    if (r_k == 4'd8) begin
                        r_state <= WAIT;
                    end else begin
                        r_k <= r_k + 4'd1;
                    end
                end
                WAIT: begin
                    r_win[8] <= mem_rd_data;
                    r_state  <= COMPUTE;
                end
                COMPUTE: begin
                    r_res_addr <= ADDR_W'(r_row * C_WIDTH + r_col);
                    r_res_mag  <= w_mag;
                    r_state    <= EMIT;
                end
                EMIT: begin
                    if (res_ready) begin
                        r_k <= 4'd0;
                        if ((r_row == C_LAST_R) && (r_col == C_LAST_C)) begin
                            r_state <= DONE;
                            r_row   <= C_ONE;
                            r_col   <= C_ONE;
                        end else begin
                            r_state <= FETCH;
                            if (r_col == C_LAST_C) begin
                                r_col <= C_ONE;
                                r_row <= r_row + C_ONE;
                            end else begin
                                r_col <= r_col + C_ONE;
                            end
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sobel_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_sched
// Purpose  : Self-checking bench for sobel_sched with a behavioural 1024x12
//            synchronous-read memory. Directed window vectors plus full
//            scans, backpressure, arbitration, abort and async reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sobel_sched;
    import sobel_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        host_wr;
    logic [9:0]  host_addr;
    logic [11:0] host_data;
    logic        host_ready;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic        mem_wr_en;
    logic [9:0]  mem_wr_addr;
    logic [11:0] mem_wr_data;
    logic [9:0]  mem_rd_addr;
    logic [11:0] mem_rd_data;
    logic        res_valid;
    logic        res_ready;
    logic [9:0]  res_addr;
    logic [11:0] res_mag;

    logic [11:0] mem [0:1023];
    logic [36:0] w_outs;

    int checks   = 0;
    int failures = 0;

    logic [9:0] rd_seq  [0:8];
    int         exp_seq [0:8];

    typedef struct packed {
        logic [8:0][11:0] win;
        logic [11:0]      mag;
    } vec_t;

    vec_t vecs [0:13];

    sobel_sched #(
        .IMG_W (32), .IMG_H (32), .ADDR_W (10), .PIX_W (12)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .host_wr     (host_wr),
        .host_addr   (host_addr),
        .host_data   (host_data),
        .host_ready  (host_ready),
        .start       (start),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_addr    (res_addr),
        .res_mag     (res_mag)
    );

    always #5 clk = ~clk;

    // Memory model: one write port, registered read
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
        mem_rd_data <= mem[mem_rd_addr];
    end

    assign w_outs = {host_ready, busy, done, mem_wr_en, res_valid,
                     mem_rd_addr, res_addr, res_mag};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int p0, input int p1, input int p2,
                                input int p3, input int p4, input int p5,
                                input int p6, input int p7, input int p8,
                                input int e);
        vec_t v;
        v.win[0] = 12'(p0); v.win[1] = 12'(p1); v.win[2] = 12'(p2);
        v.win[3] = 12'(p3); v.win[4] = 12'(p4); v.win[5] = 12'(p5);
        v.win[6] = 12'(p6); v.win[7] = 12'(p7); v.win[8] = 12'(p8);
        v.mag    = 12'(e);
        return v;
    endfunction

    task automatic host_write(input int a, input int d);
        host_wr   = 1'b1;
        host_addr = 10'(a);
        host_data = 12'(d);
        @(posedge clk); #1;
        host_wr   = 1'b0;
    endtask

    // Start a scan with the result stalled and report the first result
    task automatic first_result(output logic [9:0] a, output logic [11:0] m, output int lat);
        res_ready = 1'b0;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        lat       = 0;
        while (!res_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("first_result_seen", res_valid, 1);
        a = res_addr;
        m = res_mag;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_to_idle", {busy, res_valid, done}, 0);
    endtask

    // Full scan with bench-side raster tracking of the expected results
    task automatic run_scan(input bit bp, input bit edge_img);
        int          cyc = 0;
        int          nres = 0;
        int          er = 1;
        int          ec = 1;
        int          em;
        bit          hold = 0;
        bit          got_done = 0;
        logic [9:0]  ha = '0;
        logic [11:0] hm = '0;
        res_ready = 1'b1;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        chk("scan_busy", busy, 1);
        while (cyc < 40000) begin
            if (done) begin
                got_done = 1;
                break;
            end
            if (edge_img && !bp && cyc < 9) rd_seq[cyc] = mem_rd_addr;
            if (hold) chk("bp_stable", {res_valid, res_addr, res_mag}, {1'b1, ha, hm});
            res_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            hold = res_valid && !res_ready;
            ha   = res_addr;
            hm   = res_mag;
            if (res_valid && res_ready) begin
                em = (edge_img && (ec == 15 || ec == 16)) ? PIX_MAX : 0;
                chk("res_addr", res_addr, er * 32 + ec);
                chk("res_mag", res_mag, em);
                nres++;
                if (ec == 30) begin
                    ec = 1;
                    er++;
                end else begin
                    ec++;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("scan_done_seen", got_done, 1);
        chk("scan_result_count", nres, 900);
        if (!bp) chk("scan_done_cycle", cyc, 10800);
        @(posedge clk); #1;
        chk("done_one_cycle", {done, host_ready, busy}, {1'b0, 1'b1, 1'b0});
    endtask

    initial begin
        logic [9:0]  a;
        logic [11:0] m;
        int          lat;
        int          n;

        rst_n = 1'b0; host_wr = 1'b0; host_addr = '0; host_data = '0;
        start = 1'b0; abort = 1'b0; res_ready = 1'b0;
        exp_seq = '{0, 1, 2, 32, 33, 34, 64, 65, 66};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", w_outs, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_ready_busy", {host_ready, busy}, 2'b10);

        // Window vectors for pixel (1,1): p0..p8 -> expected magnitude
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0, 100, 0, 0, 100, 0, 0, 100, 400);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 100, 100, 100, 400);
        vecs[3]  = mk(100, 0, 0, 100, 0, 0, 100, 0, 0, 400);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 4095, 4095);
        vecs[5]  = mk(10, 0, 0, 0, 0, 0, 0, 0, 0, 20);
        vecs[6]  = mk(0, 0, 0, 0, 4095, 0, 0, 0, 0, 0);
        vecs[7]  = mk(0, 7, 0, 0, 0, 3, 0, 0, 0, 20);
        vecs[8]  = mk(0, 0, 4095, 0, 0, 4095, 0, 0, 4095, 4095);
        vecs[9]  = mk(0, 0, 1000, 0, 0, 0, 0, 0, 0, 2000);
        vecs[10] = mk(2730, 2730, 2730, 2730, 2730, 2730, 2730, 2730, 2730, 0);
        vecs[11] = mk(0, 0, 0, 1, 0, 0, 0, 2000, 0, 4002);
        vecs[12] = mk(0, 0, 0, 0, 0, 1000, 0, 1047, 0, 4094);
        vecs[13] = mk(0, 0, 0, 0, 0, 1000, 0, 1048, 0, 4095);

        for (int i = 0; i < 14; i++) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    host_write(r * 32 + c, int'(vecs[i].win[r * 3 + c]));
            first_result(a, m, lat);
            chk("vec_addr", a, 33);
            chk("vec_mag", m, vecs[i].mag);
            chk("vec_latency", lat, 11);
            do_abort();
        end

        // Flat image
        for (int i = 0; i < 1024; i++) host_write(i, 12'hAAA);
        run_scan(1'b0, 1'b0);

        // Vertical edge, ready held high then randomly toggled
        for (int i = 0; i < 1024; i++) host_write(i, ((i % 32) >= 16) ? 12'hFFF : 12'h000);
        run_scan(1'b0, 1'b1);
        for (int i = 0; i < 9; i++) chk("rd_addr_seq", rd_seq[i], exp_seq[i]);
        run_scan(1'b1, 1'b1);

        // Arbitration: write and start together, then write and start while busy
        res_ready = 1'b0;
        host_wr = 1'b1; host_addr = 10'd500; host_data = 12'h123; start = 1'b1;
        #1;
        chk("arb_wr_with_start", {host_ready, mem_wr_en}, 2'b11);
        @(posedge clk); #1;
        host_wr = 1'b0; start = 1'b0;
        chk("arb_write_landed", mem[500], 12'h123);
        chk("arb_scan_started", busy, 1);
        host_wr = 1'b1; host_addr = 10'd501; host_data = 12'h456;
        #1;
        chk("arb_busy_blocks", {host_ready, mem_wr_en}, 2'b00);
        @(posedge clk); #1;
        host_wr = 1'b0;
        chk("arb_mem_unchanged", mem[501], 12'hFFF);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 2;
        while (!res_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("start_busy_ignored_lat", lat, 11);
        chk("start_busy_ignored_addr", res_addr, 33);
        do_abort();

        // Abort in EMIT of the fifth pixel, with res_ready also high
        res_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        lat = 0;
        while (n < 5 && lat < 200) begin
            if (res_valid) n++;
            if (n < 5) begin
                @(posedge clk); #1;
                lat++;
            end
        end
        chk("abort_pixel5_addr", res_addr, 37);
        do_abort();
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (done || busy) n++;
            @(posedge clk); #1;
        end
        chk("abort_no_done", n, 0);
        first_result(a, m, lat);
        chk("abort_restart_addr", a, 33);
        do_abort();

        // Asynchronous reset in the middle of FETCH
        res_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("pre_reset_fetching", mem_rd_addr, 32);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", w_outs, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("after_reset_idle", {host_ready, busy}, 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
